// File: rtl/nq_fetch_pkg.sv
// Shared types and constants for the instruction fetch master and its pair register.
package nq_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } fetch_state_t;

  localparam int INST_W     = 16;
  localparam int WORD_BYTES = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_master_if.sv
// APB read bus between the fetch master and the instruction memory slave.
interface inst_fetch_master_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/inst_pair_reg.sv
// Holds the fetched instruction pair, its PC, and the flag that marks an
// in-flight fetch as stale after a redirect.
module inst_pair_reg
  import nq_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              discard_set,
  input  logic              discard_clr,
  input  logic [31:0]       word,
  input  logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst1,
  output logic [INST_W-1:0] inst2,
  output logic [ADDR_W-1:0] pc_out,
  output logic              discard
);

  logic [INST_W-1:0] inst1_q, inst1_d;
  logic [INST_W-1:0] inst2_q, inst2_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              discard_q, discard_d;

  always_comb begin
    inst1_d   = inst1_q;
    inst2_d   = inst2_q;
    pc_out_d  = pc_out_q;
    discard_d = discard_q;
    if (load) begin
      inst1_d  = word[INST_W-1:0];
      inst2_d  = word[2*INST_W-1:INST_W];
      pc_out_d = pc;
    end
    if (discard_clr) discard_d = 1'b0;
    if (discard_set) discard_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst1_q   <= '0;
      inst2_q   <= '0;
      pc_out_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      inst1_q   <= inst1_d;
      inst2_q   <= inst2_d;
      pc_out_q  <= pc_out_d;
      discard_q <= discard_d;
    end
  end

  assign inst1   = inst1_q;
  assign inst2   = inst2_q;
  assign pc_out  = pc_out_q;
  assign discard = discard_q;

endmodule

// File: rtl/inst_fetch_master.sv
// APB read initiator feeding the prefetch buffer with 16-bit instruction pairs.
// Optional sticky slave-error handling is enabled by defining INST_FETCH_ERR_EN.
module inst_fetch_master
  import nq_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_master_if.master apb,
  input  logic                enable,
  input  logic                stall_flg,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic [INST_W-1:0]   inst1,
  output logic [INST_W-1:0]   inst2,
  output logic                write,
  output logic [ADDR_W-1:0]   PC_out,
  output logic                fetch_err
);

  fetch_state_t      state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              write_q, write_d;
  logic              err_q, err_d;

  logic              pair_load;
  logic              discard_set;
  logic              discard_clr;
  logic              discard;
  logic              accept;
  logic              slv_err;
  logic [ADDR_W-1:0] new_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [1:0]        unused_rpc_lo;

  assign unused_rpc_lo = redirect_pc[1:0];

`ifdef INST_FETCH_ERR_EN
  assign slv_err = apb.pslverr;
`else
  logic unused_pslverr;
  assign unused_pslverr = apb.pslverr;
  assign slv_err        = 1'b0;
`endif

  assign accept  = enable && !stall_flg;
  assign new_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign next_pc = pc_q + ADDR_W'(WORD_BYTES);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pc_d        = pc_q;
    write_d     = 1'b0;
    err_d       = err_q;
    pair_load   = 1'b0;
    discard_set = 1'b0;
    discard_clr = 1'b0;

    if (redirect) begin
      pc_d  = new_pc;
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!redirect && !stall_flg && !err_q) begin
          psel_d  = 1'b1;
          paddr_d = pc_q;
          state_d = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
        if (redirect) discard_set = 1'b1;
      end
      ACCESS: begin
        if (apb.pready) begin
          penable_d = 1'b0;
          // A transfer issued before a redirect still completes, but its data is stale.
          if (redirect || discard) begin
            discard_clr = 1'b1;
            psel_d      = 1'b0;
            state_d     = IDLE;
          end else if (slv_err) begin
            err_d   = 1'b1;
            psel_d  = 1'b0;
            state_d = IDLE;
          end else begin
            pair_load = 1'b1;
            if (accept) begin
              write_d = 1'b1;
              pc_d    = next_pc;
              paddr_d = next_pc;
              state_d = SETUP;
            end else begin
              psel_d  = 1'b0;
              state_d = HOLD;
            end
          end
        end else if (redirect) begin
          discard_set = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = IDLE;
        end else if (accept) begin
          write_d = 1'b1;
          pc_d    = next_pc;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= RESET_PC;
      pc_q      <= RESET_PC;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pc_q      <= pc_d;
      write_q   <= write_d;
      err_q     <= err_d;
    end
  end

  inst_pair_reg #(
    .ADDR_W(ADDR_W)
  ) u_pair (
    .clk        (clk),
    .rst        (rst),
    .load       (pair_load),
    .discard_set(discard_set),
    .discard_clr(discard_clr),
    .word       (apb.prdata),
    .pc         (pc_q),
    .inst1      (inst1),
    .inst2      (inst2),
    .pc_out     (PC_out),
    .discard    (discard)
  );

  assign apb.paddr   = paddr_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = 1'b0;
  assign write       = write_q;
  assign fetch_err   = err_q;

endmodule

// File: doc/inst_fetch_master.md
Name: inst_fetch_master

Overview:
- APB read initiator that feeds the prefetch buffer.
- Fetches 32-bit words from instruction memory and splits each word into two 16-bit instructions (inst1 = low half, inst2 = high half).
- Presents each pair with a one-cycle `write` strobe and the word's PC.
- Sits between the instruction-memory APB slave and the prefetch buffer; honours the buffer's `enable` toggle, pipeline stall, and branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32: APB address and PC width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- paddr  out  ADDR_W  APB address; always word aligned
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  tied 0 (read only)
- prdata  in  32  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error
- enable  in  1  buffer ready-to-accept (from prefetch buffer)
- stall_flg  in  1  pipeline stall
- redirect  in  1  one-cycle branch/jump redirect request
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] forced to 0 internally
- inst1  out  16  instruction at PC_out
- inst2  out  16  instruction at PC_out+2
- write  out  1  pair-valid strobe to buffer, one cycle per pair
- PC_out  out  ADDR_W  address of the word carried by inst1/inst2
- fetch_err  out  1  sticky fetch error (optional feature)

Behaviour:
- **Reset:** asynchronous on `rst` high.
  - Values: psel=0, penable=0, paddr=RESET_PC, inst1=0, inst2=0, write=0, PC_out=0, fetch_err=0, pc=RESET_PC, discard=0, state=IDLE.
  - Reset mid-transfer drops psel/penable immediately; no completion is owed.
- **Accept condition:** accept = enable && !stall_flg.
- **FSM states:** IDLE, SETUP, ACCESS, HOLD.
  - IDLE: if !stall_flg, drive paddr=pc, psel=1, go to SETUP.
  - SETUP: penable=1, go to ACCESS. Exactly one cycle.
  - ACCESS: hold psel/penable/paddr until pready=1. On pready:
    - Drop penable.
    - Register inst1=prdata[15:0], inst2=prdata[31:15+1], PC_out=pc.
    - If accept: pulse write=1 next cycle, pc<=pc+4, start the next SETUP immediately (psel stays 1, paddr=pc+4). Back-to-back throughput is one word per 2 cycles with zero wait states.
    - Otherwise go to HOLD with psel=0.
  - HOLD: keep inst1/inst2/PC_out stable. When accept, pulse write=1 for one cycle, pc<=pc+4, go to IDLE.
- **write strobe:** never high for two consecutive cycles on the same pair. inst1/inst2/PC_out are stable on every cycle write=1.
- **Redirect (highest priority):**
  - IDLE/HOLD: pc<={redirect_pc[ADDR_W-1:2],2'b00}, held pair is discarded (no write), state becomes IDLE.
  - SETUP/ACCESS: the APB transfer is completed, not aborted. Set discard=1 and load the new pc. On pready, data is dropped, write stays 0, discard clears, state goes to IDLE.
  - redirect and pready in the same cycle: data is discarded.
  - redirect wins over accept.
- **Stall:** stall_flg only gates issue (IDLE) and delivery (ACCESS/HOLD). An in-flight APB transfer always completes.
- **Wrap-around:** pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- **Fixed outputs:** pwrite=0 at all times.

Optional Feature:
- INST_FETCH_ERR_EN defined:
  - pslverr=1 with pready=1 in ACCESS discards the data (no write), does not advance pc, sets fetch_err=1, and returns to IDLE.
  - While fetch_err=1 no new transfer issues.
  - fetch_err clears only on redirect or reset.
- Undefined: pslverr is ignored, prdata is delivered as normal, and fetch_err is tied 0.

Decomposition:
- Shared package nq_fetch_pkg:
  - fetch_state_t enum (IDLE/SETUP/ACCESS/HOLD)
  - INST_W=16, WORD_BYTES=4
  - RESET_PC default
- One natural sub-module: inst_pair_reg, holding inst1/inst2/PC_out plus the discard flag with load/hold/clear controls. The FSM and APB drive stay in the top.

Test Plan:
- Reset release, enable=1, zero-wait slave with mem[0]=32'hBBBB_AAAA, mem[4]=32'hDDDD_CCCC -> paddr 0 then 4; pairs (AAAA,BBBB,PC 0) then (CCCC,DDDD,PC 4); write pulses 2 cycles apart.
- pready held low 3 cycles on addr 8 -> psel/penable/paddr stable during the wait; exactly one write after pready.
- stall_flg=1 when pready arrives -> HOLD; outputs stable; write fires on the cycle after stall_flg drops; pc advances once.
- redirect to 32'h0000_0102 during ACCESS -> in-flight data is not delivered; next paddr=32'h0000_0100; next pair PC_out=0x100.
- RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC, second at 0.
- With INST_FETCH_ERR_EN: pslverr on addr 0x10 -> no write, fetch_err=1, no further psel. redirect to 0x20 -> fetch_err=0, fetch resumes at 0x20. Rst asserted in ACCESS -> psel=0 same cycle.
